// File: rtl/mmio_bridge.sv
// mmio_bridge: decodes core data accesses into dmem or a peripheral register file (keyboard FIFO, LED, sound, cycles).
// Reads are combinational, all state updates on the rising clk edge. Define MMIO_CYCLE_COUNTER_EN to build the CYCLES counter.
module mmio_bridge #(
    parameter int Dbits   = 32,
    parameter int KDEPTH  = 4,
    parameter int DMEM_AW = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [31:0]        mem_addr,
    input  logic               mem_wr,
    input  logic [Dbits-1:0]   mem_writedata,
    output logic [Dbits-1:0]   mem_readdata,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic               dmem_wr,
    output logic [Dbits-1:0]   dmem_writedata,
    input  logic [Dbits-1:0]   dmem_readdata,
    input  logic               key_valid,
    input  logic [7:0]         key_code,
    output logic [15:0]        led,
    output logic [Dbits-1:0]   sound_period
);
    localparam int PW = $clog2(KDEPTH);
    localparam int CW = PW + 1;

    logic          sel_dmem;
    logic          sel_io;
    logic [2:0]    offset;
    logic          io_wr;
    logic [7:0]    kfifo [KDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          overflow;
    logic          full;
    logic          pop;
    logic          push;
    logic          ovf_set;
    logic          ovf_clr;
    logic [Dbits-1:0] cycles;
    logic          unused_addr;

    assign sel_dmem = (mem_addr[31:16] == 16'h1001);
    assign sel_io   = (mem_addr[31:16] == 16'h1003);
    assign offset   = mem_addr[4:2];
    assign io_wr    = mem_wr & enable & sel_io;

    assign dmem_addr      = mem_addr[DMEM_AW+1:2];
    assign dmem_wr        = mem_wr & enable & sel_dmem;
    assign dmem_writedata = mem_writedata;
    assign unused_addr    = ^{mem_addr[15:5], mem_addr[1:0]};

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a simultaneous push.
    assign full    = (count == CW'(KDEPTH));
    assign pop     = io_wr & (offset == 3'd0) & (count != '0);
    assign push    = key_valid & (~full | pop);
    assign ovf_set = key_valid & full & ~pop;
    assign ovf_clr = io_wr & (offset == 3'd1);

    always_ff @(posedge clk) begin
        if (push) begin
            kfifo[tail] <= key_code;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led          <= '0;
            sound_period <= '0;
        end else if (io_wr) begin
            if (offset == 3'd3) begin
                led <= mem_writedata[15:0];
            end
            if (offset == 3'd4) begin
                sound_period <= mem_writedata;
            end
        end
    end

`ifdef MMIO_CYCLE_COUNTER_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles <= '0;
        end else if (enable) begin
            cycles <= cycles + 1'b1;
        end
    end
`else
    assign cycles = '0;
`endif

    always_comb begin
        mem_readdata = '0;
        if (sel_dmem) begin
            mem_readdata = dmem_readdata;
        end else if (sel_io) begin
            case (offset)
                3'd0: begin
                    if (count != '0) begin
                        mem_readdata[7:0] = kfifo[head];
                    end
                end
                3'd1: begin
                    mem_readdata[8]      = overflow;
                    mem_readdata[CW-1:0] = count;
                end
                3'd2:    mem_readdata = cycles;
                3'd3:    mem_readdata[15:0] = led;
                3'd4:    mem_readdata = sound_period;
                default: mem_readdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_bridge.sv
// Bench for mmio_bridge: directed vector table, counter/reset sequence, then random traffic against a queue-based model.
module tb_mmio_bridge;
    localparam int KDEPTH = 4;
    localparam logic [31:0] IO = 32'h1003_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        mem_wr = 1'b0;
    logic [31:0] mem_writedata = '0;
    logic [31:0] mem_readdata;
    logic [9:0]  dmem_addr;
    logic        dmem_wr;
    logic [31:0] dmem_writedata;
    logic [31:0] dmem_readdata = 32'h1234_5678;
    logic        key_valid = 1'b0;
    logic [7:0]  key_code = '0;
    logic [15:0] led;
    logic [31:0] sound_period;

    mmio_bridge #(.Dbits(32), .KDEPTH(KDEPTH), .DMEM_AW(10)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .dmem_addr(dmem_addr), .dmem_wr(dmem_wr),
        .dmem_writedata(dmem_writedata), .dmem_readdata(dmem_readdata),
        .key_valid(key_valid), .key_code(key_code), .led(led), .sound_period(sound_period)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  q[$];
    bit          m_ovf;
    logic [15:0] m_led;
    logic [31:0] m_sound;
    logic [31:0] m_cyc;

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic        en;
        logic        kv;
        logic [7:0]  kc;
        logic [31:0] exp;
    } vec_t;
    vec_t tv[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_ovf = 0;
        m_led = '0;
        m_sound = '0;
        m_cyc = '0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:16] == 16'h1001) return dmem_readdata;
        if (a[31:16] != 16'h1003) return 32'h0;
        case (a[4:2])
            3'd0: return (q.size() > 0) ? {24'h0, q[0]} : 32'h0;
            3'd1: return (m_ovf ? 32'h100 : 32'h0) + q.size();
`ifdef MMIO_CYCLE_COUNTER_EN
            3'd2: return m_cyc;
`else
            3'd2: return 32'h0;
`endif
            3'd3: return {16'h0, m_led};
            3'd4: return m_sound;
            default: return 32'h0;
        endcase
    endfunction

    // One bus cycle: drive, check combinational outputs, advance model, clock, check registers.
    task automatic cyc(input logic [31:0] a, input logic w, input logic [31:0] d, input logic en,
                       input logic kv, input logic [7:0] kc, input bit use_exp, input logic [31:0] exp);
        bit io_w;
        bit popped;
        mem_addr = a; mem_wr = w; mem_writedata = d; enable = en; key_valid = kv; key_code = kc;
        #1;
        if (use_exp) check("vector_readdata", mem_readdata, exp);
        check("readdata", mem_readdata, model_read(a));
        check("dmem_wr", {31'h0, dmem_wr}, {31'h0, w & en & (a[31:16] == 16'h1001)});
        check("dmem_addr", {22'h0, dmem_addr}, {22'h0, a[11:2]});
        check("dmem_writedata", dmem_writedata, d);
        io_w = w && en && (a[31:16] == 16'h1003);
        popped = io_w && (a[4:2] == 3'd0) && (q.size() > 0);
        if (popped) void'(q.pop_front());
        if (io_w && a[4:2] == 3'd1) m_ovf = 0;
        if (kv) begin
            if (q.size() < KDEPTH) q.push_back(kc);
            else m_ovf = 1;
        end
        if (io_w && a[4:2] == 3'd3) m_led = d[15:0];
        if (io_w && a[4:2] == 3'd4) m_sound = d;
        if (en) m_cyc = m_cyc + 1;
        @(posedge clk);
        #1;
        check("led", {16'h0, led}, {16'h0, m_led});
        check("sound_period", sound_period, m_sound);
    endtask

    function automatic void add(input logic [31:0] a, input logic w, input logic [31:0] d, input logic en,
                                input logic kv, input logic [7:0] kc, input logic [31:0] exp);
        vec_t v;
        v.a = a; v.w = w; v.d = d; v.en = en; v.kv = kv; v.kc = kc; v.exp = exp;
        tv.push_back(v);
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        enable = 1'b0; mem_wr = 1'b0; key_valid = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        do_reset();
        check("reset_led", {16'h0, led}, 32'h0);
        check("reset_sound", sound_period, 32'h0);

        // Ten enabled cycles after reset, two of them loading LED/SOUND so the later reset is observable.
        cyc(IO + 32'hC, 1, 32'h0000_00FF, 1, 0, 8'h0, 0, 0);
        cyc(IO + 32'h10, 1, 32'hDEAD_0001, 1, 0, 8'h0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(32'h0, 0, 32'h0, 1, 0, 8'h0, 0, 0);
`ifdef MMIO_CYCLE_COUNTER_EN
        cyc(IO + 32'h8, 0, 32'h0, 0, 0, 8'h0, 1, 32'd10);
`else
        cyc(IO + 32'h8, 0, 32'h0, 0, 0, 8'h0, 1, 32'd0);
`endif
        mem_addr = IO + 32'h8; mem_wr = 1'b0; enable = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("midreset_cycles", mem_readdata, 32'h0);
        check("midreset_led", {16'h0, led}, 32'h0);
        check("midreset_sound", sound_period, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Directed table: expected value is mem_readdata before the clock edge.
        add(IO + 32'h0, 0, 0, 0, 0, 8'h00, 32'h0);
        add(IO + 32'h4, 0, 0, 0, 0, 8'h00, 32'h0);
        add(IO + 32'h8, 0, 0, 0, 0, 8'h00, 32'h0);
        add(IO + 32'hC, 0, 0, 0, 0, 8'h00, 32'h0);
        add(IO + 32'h10, 0, 0, 0, 0, 8'h00, 32'h0);
        add(IO + 32'hC, 1, 32'h0000_ABCD, 1, 0, 8'h00, 32'h0);
        add(IO + 32'hC, 0, 0, 0, 0, 8'h00, 32'h0000_ABCD);
        add(IO + 32'hC, 1, 32'h0000_1111, 0, 0, 8'h00, 32'h0000_ABCD);
        add(IO + 32'hC, 0, 0, 0, 0, 8'h00, 32'h0000_ABCD);
        add(IO + 32'hC, 1, 32'hFFFF_5A5A, 1, 0, 8'h00, 32'h0000_ABCD);
        add(IO + 32'hC, 0, 0, 0, 0, 8'h00, 32'h0000_5A5A);
        add(IO + 32'h10, 1, 32'hDEAD_BEEF, 1, 0, 8'h00, 32'h0);
        add(IO + 32'h10, 0, 0, 0, 0, 8'h00, 32'hDEAD_BEEF);
        add(IO + 32'h4, 0, 0, 0, 1, 8'h1C, 32'h0);
        add(IO + 32'h4, 0, 0, 0, 1, 8'h32, 32'h1);
        add(IO + 32'h4, 0, 0, 0, 1, 8'h21, 32'h2);
        add(IO + 32'h4, 0, 0, 0, 1, 8'h23, 32'h3);
        add(IO + 32'h4, 0, 0, 0, 1, 8'h24, 32'h4);
        add(IO + 32'h4, 0, 0, 0, 0, 8'h00, 32'h104);
        add(IO + 32'h0, 0, 0, 0, 0, 8'h00, 32'h1C);
        add(IO + 32'h0, 1, 0, 1, 0, 8'h00, 32'h1C);
        add(IO + 32'h0, 1, 0, 1, 0, 8'h00, 32'h32);
        add(IO + 32'h0, 1, 0, 1, 0, 8'h00, 32'h21);
        add(IO + 32'h0, 1, 0, 1, 0, 8'h00, 32'h23);
        add(IO + 32'h0, 0, 0, 0, 0, 8'h00, 32'h0);
        add(IO + 32'h4, 1, 0, 1, 0, 8'h00, 32'h100);
        add(IO + 32'h4, 0, 0, 0, 0, 8'h00, 32'h0);
        add(IO + 32'h4, 0, 0, 0, 1, 8'h01, 32'h0);
        add(IO + 32'h4, 0, 0, 0, 1, 8'h02, 32'h1);
        add(IO + 32'h4, 0, 0, 0, 1, 8'h03, 32'h2);
        add(IO + 32'h4, 0, 0, 0, 1, 8'h04, 32'h3);
        add(IO + 32'h0, 1, 0, 1, 1, 8'h55, 32'h01);
        add(IO + 32'h4, 0, 0, 0, 0, 8'h00, 32'h004);
        add(IO + 32'h0, 1, 0, 1, 0, 8'h00, 32'h02);
        add(IO + 32'h0, 1, 0, 1, 0, 8'h00, 32'h03);
        add(IO + 32'h0, 1, 0, 1, 0, 8'h00, 32'h04);
        add(IO + 32'h0, 1, 0, 1, 0, 8'h00, 32'h55);
        add(IO + 32'h0, 1, 0, 1, 0, 8'h00, 32'h0);
        add(IO + 32'h4, 0, 0, 0, 0, 8'h00, 32'h0);
        add(IO + 32'h4, 0, 0, 0, 1, 8'h0A, 32'h0);
        add(IO + 32'h4, 0, 0, 0, 1, 8'h0B, 32'h1);
        add(IO + 32'h4, 0, 0, 0, 1, 8'h0C, 32'h2);
        add(IO + 32'h4, 0, 0, 0, 1, 8'h0D, 32'h3);
        add(IO + 32'h4, 1, 0, 1, 1, 8'h0E, 32'h4);
        add(IO + 32'h4, 0, 0, 0, 0, 8'h00, 32'h104);
        add(IO + 32'h4, 1, 0, 1, 0, 8'h00, 32'h104);
        add(IO + 32'h0, 0, 0, 0, 0, 8'h00, 32'h0A);
        add(32'h1001_0008, 1, 32'hDEAD_BEEF, 1, 0, 8'h00, 32'h1234_5678);
        add(32'h2000_0000, 1, 32'hDEAD_BEEF, 1, 0, 8'h00, 32'h0);
        add(IO + 32'h14, 1, 32'hFFFF_FFFF, 1, 0, 8'h00, 32'h0);
        add(IO + 32'h4, 0, 0, 0, 0, 8'h00, 32'h004);
        foreach (tv[i]) cyc(tv[i].a, tv[i].w, tv[i].d, tv[i].en, tv[i].kv, tv[i].kc, 1, tv[i].exp);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: a = IO + ($urandom_range(0, 7) << 2);
                1: a = {16'h1001, 16'($urandom)};
                2: a = $urandom;
                default: a = IO + ($urandom_range(0, 1) << 2);
            endcase
            dmem_readdata = $urandom;
            cyc(a, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 9) < 4), 8'($urandom), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
